gb_bus_arbiter: RTL
===================

// Module: gb_bus_arbiter
// PURPOSE
//  Parametrised multi-master front end for the system bus; replaces the fixed CPU/OAM-DMA mux.
//  Arbitrates master 0 (CPU) against DMA masters 1..NUM_MASTERS-1 (OAM DMA, HDMA, ...) for one downstream bus.
//  Supports locked bursts and registered one-cycle read return.
//  CPU accesses to the HRAM window take a private bypass port and are never blocked by DMA.
// PARAMETERS
//  NUM_MASTERS  3       masters incl. CPU at index 0; legal 1..8
//  ADDR_W       16      address width
//  DATA_W       8       data width
//  HRAM_LO      16'hFF80  first bypass address (inclusive)
//  HRAM_HI      16'hFFFE  last bypass address (inclusive)
// PORTS
//  clk         in   1                    system clock
//  reset       in   1                    synchronous, active-high
//  m_req       in   NUM_MASTERS          per-master request, held until m_gnt
//  m_we        in   NUM_MASTERS          1=write, 0=read
//  m_lock      in   NUM_MASTERS          hold ownership across consecutive requests
//  m_addr      in   NUM_MASTERS*ADDR_W   packed; master i at [i*ADDR_W +: ADDR_W]
//  m_wdata     in   NUM_MASTERS*DATA_W   packed write data
//  m_gnt       out  NUM_MASTERS          access accepted this cycle (combinational)
//  m_rvalid    out  NUM_MASTERS          read data valid; exactly 1 cycle after read grant
//  m_rdata     out  NUM_MASTERS*DATA_W   packed registered read data
//  s_addr/s_wdata out ADDR_W/DATA_W      downstream bus, driven from winner
//  s_read_en/s_write_en out 1            asserted only in grant cycle
//  s_rdata     in   DATA_W               downstream read data, combinational
//  h_addr/h_wdata out ADDR_W/DATA_W      HRAM bypass bus (CPU only)
//  h_read_en/h_write_en out 1; h_rdata in DATA_W
//  owner       out  $clog2(NUM_MASTERS)+1  current downstream owner index
//  locked      out  1                    FSM in OWNED
//  stall_clr   in   1                    clears stall counters (feature only)
//  stall_cnt   out  NUM_MASTERS*16       per-master stall counters
// BEHAVIOUR
//  Reset: m_gnt/m_rvalid/m_rdata=0, s_*/h_* enables=0, owner=0, locked=0, FSM=IDLE, rr_ptr=1.
//  Bypass: m_req[0] with m_addr[0] in [HRAM_LO:HRAM_HI] -> h_* driven, m_gnt[0]=1 same cycle, any FSM state.
//   Bypass request never participates in downstream arbitration.
//  Arbitration (IDLE): any DMA request wins over CPU. DMA masters use round-robin from rr_ptr;
//   after a DMA grant rr_ptr = winner+1, wrapping NUM_MASTERS-1 -> 1. CPU is granted only when no DMA req.
//  FSM IDLE->OWNED: granted master has m_lock=1; owner latched.
//  OWNED: only owner granted downstream. Owner m_req=0 with m_lock=1 -> bus idle, ownership kept.
//  OWNED->IDLE: owner m_lock=0; arbitration in same cycle per IDLE rules, releasing master eligible.
//  Reads: s_rdata/h_rdata registered at grant edge into master's m_rdata slot; m_rvalid 1 cycle later, 1 cycle wide.
//   Back-to-back reads give m_rvalid every cycle. m_rdata holds value until next read return.
//  Writes: s_write_en/h_write_en one cycle; no m_rvalid.
//  Same-cycle CPU bypass read + DMA downstream read: both granted; both rvalid next cycle.
//  No downstream grant: s_addr=0, s_wdata=0; bus enables low.
//  NUM_MASTERS=1: pure CPU pass-through with registered reads; FSM still honours m_lock.
//  Reset mid-burst: FSM->IDLE; pending m_rvalid dropped.
// CONFIGURATION
//  GB_ARB_STALL_CNT_EN defined: per-master 16-bit saturating counters.
//   Count cycles with m_req=1 && m_gnt=0; saturate at 16'hFFFF.
//   Cleared by reset or stall_clr; stall_clr wins over an increment in the same cycle.
//  Undefined: stall_cnt tied 0, stall_clr ignored, no counter flops.
// TESTING
//  CPU read 16'hC000, s_rdata=8'h5A -> s_read_en in grant cycle; rvalid[0] next cycle; rdata[0]=8'h5A.
//  CPU and master 1 request simultaneously -> m_gnt=3'b010; CPU granted next cycle after master 1 drops req.
//  Master 1 locked 160-byte burst, CPU reads 16'h8000 -> CPU gnt=0 throughout; CPU granted cycle after lock release.
//  During master 1 lock, CPU reads 16'hFF90, h_rdata=8'h33 -> gnt[0] same cycle; rdata[0]=8'h33 next cycle.
//  Masters 1 and 2 continuously request, unlocked -> grants alternate 1,2,1,2 starting at 1.
//  GB_ARB_STALL_CNT_EN: CPU blocked 10 cycles -> stall_cnt[0]=10; stall_clr -> 0 next cycle.

Source files
------------

// File: rtl/gb_bus_arbiter_if.sv
// gb_bus_arbiter_if: request/grant/read-return signals of the bus masters,
// plus the downstream system bus and the private HRAM bypass bus.
// Modport slave is the arbiter's view. Modport master is the view of the
// masters and memories around it.
interface gb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
);
    // Master side (packed; master i at [i*W +: W])
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_we;
    logic [NUM_MASTERS-1:0]        m_lock;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]        m_gnt;
    logic [NUM_MASTERS-1:0]        m_rvalid;
    logic [NUM_MASTERS*DATA_W-1:0] m_rdata;

    // Downstream system bus
    logic [ADDR_W-1:0]             s_addr;
    logic [DATA_W-1:0]             s_wdata;
    logic                          s_read_en;
    logic                          s_write_en;
    logic [DATA_W-1:0]             s_rdata;

    // HRAM bypass bus (CPU only)
    logic [ADDR_W-1:0]             h_addr;
    logic [DATA_W-1:0]             h_wdata;
    logic                          h_read_en;
    logic                          h_write_en;
    logic [DATA_W-1:0]             h_rdata;

    modport slave (
        input  m_req, m_we, m_lock, m_addr, m_wdata, s_rdata, h_rdata,
        output m_gnt, m_rvalid, m_rdata,
               s_addr, s_wdata, s_read_en, s_write_en,
               h_addr, h_wdata, h_read_en, h_write_en
    );

    modport master (
        output m_req, m_we, m_lock, m_addr, m_wdata, s_rdata, h_rdata,
        input  m_gnt, m_rvalid, m_rdata,
               s_addr, s_wdata, s_read_en, s_write_en,
               h_addr, h_wdata, h_read_en, h_write_en
    );
endinterface

// File: rtl/gb_bus_arbiter.sv
// gb_bus_arbiter: multi-master front end for the system bus.
// Master 0 is the CPU. Masters 1..NUM_MASTERS-1 are DMA engines that always
// beat the CPU and rotate among themselves round-robin. A granted master with
// m_lock set keeps the bus (OWNED) until it drops m_lock. CPU accesses to the
// HRAM window use the bypass port and are never blocked.
// Reads return one cycle after the grant through registered m_rdata/m_rvalid.
// Optional feature: define GB_ARB_STALL_CNT_EN for per-master 16-bit
// saturating stall counters. Otherwise stall_cnt_o is 0.
module gb_bus_arbiter #(
    parameter int                NUM_MASTERS = 3,
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] HRAM_LO     = 16'hFF80,
    parameter logic [ADDR_W-1:0] HRAM_HI     = 16'hFFFE
) (
    input  logic                              clk,
    input  logic                              reset,
    gb_bus_arbiter_if.slave                   bus,
    output logic [$clog2(NUM_MASTERS):0]      owner_o,
    output logic                              locked_o,
    input  logic                              stall_clr_i,
    output logic [NUM_MASTERS*16-1:0]         stall_cnt_o
);
    localparam int OWN_W = $clog2(NUM_MASTERS) + 1;

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t                        state_q;
    logic [OWN_W-1:0]              owner_q;
    logic [OWN_W-1:0]              rr_ptr_q;
    logic [OWN_W-1:0]              rr_ptr_d;
    logic [NUM_MASTERS-1:0]        rvalid_q;
    logic [NUM_MASTERS*DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0]             cpu_addr;
    logic                          bypass_hit;
    logic [NUM_MASTERS-1:0]        ds_req;
    logic                          owner_hold;
    logic                          grant_valid;
    logic [OWN_W-1:0]              winner;
    logic [ADDR_W-1:0]             winner_addr;
    logic [DATA_W-1:0]             winner_wdata;
    logic                          winner_we;
    logic                          winner_lock;

    assign cpu_addr   = bus.m_addr[ADDR_W-1:0];
    // Grants are suppressed while reset is held.
    assign bypass_hit = !reset && bus.m_req[0] &&
                        (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);

    // Downstream requests: a CPU bypass access never competes for the bus.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        ds_req    = bus.m_req;
        ds_req[0] = bus.m_req[0] && !bypass_hit;
        if (reset) ds_req = '0;
    end

    // Pick the downstream winner: locked owner only, else DMA round-robin, else CPU.
    always_comb begin
        int idx;
        owner_hold  = 1'b0;
        grant_valid = 1'b0;
        winner      = '0;
        idx         = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (state_q == ST_OWNED && owner_q == OWN_W'(i) && bus.m_lock[i])
                owner_hold = 1'b1;
        end
        if (owner_hold) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (owner_q == OWN_W'(i) && ds_req[i]) begin
                    grant_valid = 1'b1;
                    winner      = OWN_W'(i);
                end
            end
        end else begin
            if (ds_req[0]) begin
                grant_valid = 1'b1;
                winner      = '0;
            end
            // Walk furthest-first so the DMA master closest to rr_ptr is assigned last.
            for (int k = NUM_MASTERS - 2; k >= 0; k--) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_MASTERS) idx = idx - (NUM_MASTERS - 1);
                for (int j = 1; j < NUM_MASTERS; j++) begin
                    if (idx == j && ds_req[j]) begin
                        grant_valid = 1'b1;
                        winner      = OWN_W'(j);
                    end
                end
            end
        end
    end

    // Select the winner's request fields.
    always_comb begin
        winner_addr  = '0;
        winner_wdata = '0;
        winner_we    = 1'b0;
        winner_lock  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (winner == OWN_W'(i)) begin
                winner_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
                winner_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
                winner_we    = bus.m_we[i];
                winner_lock  = bus.m_lock[i];
            end
        end
    end

    // Next round-robin pointer: one past the DMA winner, wrapping back to master 1.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid && winner != '0)
            rr_ptr_d = (winner == OWN_W'(NUM_MASTERS - 1)) ? OWN_W'(1) : winner + OWN_W'(1);
    end

    // Grants and bus drive. Idle buses are driven to zero.
    always_comb begin
        bus.m_gnt = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_valid && winner == OWN_W'(i)) bus.m_gnt[i] = 1'b1;
        end
        if (bypass_hit) bus.m_gnt[0] = 1'b1;

        bus.s_addr     = grant_valid ? winner_addr  : '0;
        bus.s_wdata    = grant_valid ? winner_wdata : '0;
        bus.s_read_en  = grant_valid && !winner_we;
        bus.s_write_en = grant_valid &&  winner_we;

        bus.h_addr     = bypass_hit ? cpu_addr : '0;
        bus.h_wdata    = bypass_hit ? bus.m_wdata[DATA_W-1:0] : '0;
        bus.h_read_en  = bypass_hit && !bus.m_we[0];
        bus.h_write_en = bypass_hit &&  bus.m_we[0];
    end

    // Ownership FSM: enter OWNED on a locked grant, stay while the owner holds m_lock.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= OWN_W'(1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (grant_valid) owner_q <= winner;
            if (grant_valid && winner_lock) state_q <= ST_OWNED;
            else if (owner_hold)            state_q <= ST_OWNED;
            else                            state_q <= ST_IDLE;
        end
    end

    // Read return: capture read data at the grant edge; pulse rvalid for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= '0;
            // NOTE: the read-data slots are reset because m_rdata must read 0 out of reset.
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (bus.m_gnt[i] && !bus.m_we[i]) begin
                    rvalid_q[i] <= 1'b1;
                    rdata_q[i*DATA_W +: DATA_W] <= (i == 0 && bypass_hit) ? bus.h_rdata : bus.s_rdata;
                end
            end
        end
    end

    assign bus.m_rvalid = rvalid_q;
    assign bus.m_rdata  = rdata_q;
    assign owner_o      = owner_q;
    assign locked_o     = (state_q == ST_OWNED);

`ifdef GB_ARB_STALL_CNT_EN
    logic [NUM_MASTERS*16-1:0] stall_cnt_q;

    // Saturating stall counters: count cycles requesting without a grant; clear wins.
    always_ff @(posedge clk) begin
        if (reset || stall_clr_i) begin
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (bus.m_req[i] && !bus.m_gnt[i] && stall_cnt_q[i*16 +: 16] != 16'hFFFF)
                    stall_cnt_q[i*16 +: 16] <= stall_cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = stall_clr_i;
    assign stall_cnt_o      = '0;
`endif
endmodule
